// File: rtl/decoder_3_8_walk.sv
// Streaming 3-to-8 decoder: one request (start code + run length) becomes a burst of
// one-hot words walking upward with wrap-around. Define DEC38_ACTIVE_LOW_EN for active-low words.
module decoder_3_8_walk (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic [2:0] in_len,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_onehot,
    output logic       out_last,
    output logic       busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready on that side.
    // valid never depends on ready; in_ready may depend on out_ready so a new burst
    // can be taken on the same edge the previous last beat leaves.

`ifdef DEC38_ACTIVE_LOW_EN
    localparam logic [7:0] POL_MASK = 8'hFF;
`else
    localparam logic [7:0] POL_MASK = 8'h00;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cur_q, cur_d;
    logic [2:0] rem_q, rem_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_onehot_q, out_onehot_d;
    logic       out_last_q, out_last_d;

    logic       accept;
    logic       beat;
    logic [2:0] cur_next;

    assign beat     = out_valid_q && out_ready;
    assign in_ready = (state_q == IDLE) || (beat && out_last_q);
    assign accept   = in_valid && in_ready;
    assign cur_next = cur_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rem_d        = rem_q;
        out_valid_d  = out_valid_q;
        out_onehot_d = out_onehot_q;
        out_last_d   = out_last_q;
        if (accept) begin
            state_d      = RUN;
            cur_d        = in_code;
            rem_d        = in_len;
            out_valid_d  = 1'b1;
            out_onehot_d = (8'd1 << in_code) ^ POL_MASK;
            out_last_d   = (in_len == 3'd0);
        end else if (beat) begin
            if (out_last_q) begin
                state_d      = IDLE;
                out_valid_d  = 1'b0;
                out_onehot_d = POL_MASK;
                out_last_d   = 1'b0;
            end else begin
                // 3-bit arithmetic gives the 7 -> 0 wrap for free
                cur_d        = cur_next;
                rem_d        = rem_q - 3'd1;
                out_onehot_d = (8'd1 << cur_next) ^ POL_MASK;
                out_last_d   = (rem_q == 3'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cur_q        <= 3'd0;
            rem_q        <= 3'd0;
            out_valid_q  <= 1'b0;
            out_onehot_q <= POL_MASK;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            rem_q        <= rem_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_last_q   <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q == RUN);

endmodule
